// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: holds the PC, fetches over a req/ack
// handshake, and selects the next PC from the Control branch/jump decisions.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] retire_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic        loadInstr;
  logic        advance;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] retireCount;
  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Ack only matters in FETCH and branch/jump only in an unstalled DECODE,
  // so stray handshakes elsewhere can never touch the datapath registers.
  always_comb begin
    nextState = state;
    loadInstr = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        nextState = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          loadInstr = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        if (!stall) begin
          advance   = 1'b1;
          nextState = FETCH;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign pcPlus4      = pcReg + 32'd4;
  assign branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
  assign branchTarget = pcPlus4 + branchOffset;
  assign jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};

  // Jump outranks a taken branch when Control asserts both.
  always_comb begin
    nextPc = pcPlus4;
    if (jump) begin
      nextPc = jumpTarget;
    end else if (branch && zero) begin
      nextPc = branchTarget;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg       <= RESET_PC_ALIGNED;
      instrReg    <= 32'd0;
      retireCount <= 32'd0;
    end else begin
      if (loadInstr) begin
        instrReg <= imem_rdata;
      end
      if (advance) begin
        pcReg       <= nextPc;
        retireCount <= retireCount + 32'd1;
      end
    end
  end

  assign imem_req     = (state == FETCH);
  assign instr_valid  = (state == DECODE);
  assign imem_addr    = pcReg;
  assign pc           = pcReg;
  assign pc_plus4     = pcPlus4;
  assign instr        = instrReg;
  assign op           = instrReg[31:26];
  assign retire_count = retireCount;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit, checked against a transaction-level
// model of PC sequencing and retirement.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] retire_count;

  int          checkCount;
  int          passCount;
  logic [31:0] expPc;
  logic [31:0] expRet;
  logic [31:0] expInstr;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .instr        (instr),
    .op           (op),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Architectural next-PC rule: jump, else taken beq, else fall through.
  function automatic logic [31:0] modelNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic br, input logic z, input logic j);
    logic signed [15:0] imm;
    logic [31:0] seqPc;
    imm   = word[15:0];
    seqPc = curPc + 32'd4;
    if (j)
      return (seqPc & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    else if (br && z)
      return seqPc + 32'(int'(imm) * 4);
    else
      return seqPc;
  endfunction

  // One full instruction: wait states, ack, optional stall, then retirement.
  task automatic applyStimulus(input logic [31:0] word, input int waitCycles, input int stallCycles,
                               input logic br, input logic z, input logic j, input logic strayAck);
    checkOutput("fetchReq", imem_req, 1'b1);
    checkOutput("fetchAddr", imem_addr, expPc);
    checkOutput("fetchValid", instr_valid, 1'b0);
    checkOutput("staleInstr", instr, expInstr);
    for (int i = 0; i < waitCycles; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      branch     = 1'($urandom);
      zero       = 1'($urandom);
      jump       = 1'($urandom);
      @(negedge clk);
      checkOutput("addrStable", imem_addr, expPc);
      checkOutput("reqHeld", imem_req, 1'b1);
      checkOutput("instrHeld", instr, expInstr);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    expInstr = word;
    checkOutput("decodeValid", instr_valid, 1'b1);
    checkOutput("decodeReq", imem_req, 1'b0);
    checkOutput("instr", instr, word);
    checkOutput("op", {26'd0, op}, {26'd0, word[31:26]});
    checkOutput("pc", pc, expPc);
    checkOutput("pcPlus4", pc_plus4, expPc + 32'd4);
    for (int i = 0; i < stallCycles; i++) begin
      stall      = 1'b1;
      imem_ack   = strayAck;
      imem_rdata = $urandom;
      branch     = 1'($urandom);
      zero       = 1'($urandom);
      jump       = 1'($urandom);
      @(negedge clk);
      checkOutput("stallValid", instr_valid, 1'b1);
      checkOutput("stallInstr", instr, word);
      checkOutput("stallPc", pc, expPc);
      checkOutput("stallRetire", retire_count, expRet);
    end
    stall      = 1'b0;
    imem_ack   = strayAck;
    imem_rdata = $urandom;
    branch     = br;
    zero       = z;
    jump       = j;
    @(negedge clk);
    imem_ack = 1'b0;
    branch   = 1'b0;
    zero     = 1'b0;
    jump     = 1'b0;
    expPc  = modelNextPc(expPc, word, br, z, j);
    expRet = expRet + 32'd1;
    checkOutput("retireReq", imem_req, 1'b1);
    checkOutput("retireValid", instr_valid, 1'b0);
    checkOutput("nextPc", pc, expPc);
    checkOutput("retireCount", retire_count, expRet);
    checkOutput("strayAckInstr", instr, word);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Req"}, imem_req, 1'b0);
    checkOutput({tag, "Valid"}, instr_valid, 1'b0);
    checkOutput({tag, "Pc"}, pc, 32'h0);
    checkOutput({tag, "PcPlus4"}, pc_plus4, 32'h4);
    checkOutput({tag, "Instr"}, instr, 32'h0);
    checkOutput({tag, "Op"}, {26'd0, op}, 32'h0);
    checkOutput({tag, "Retire"}, retire_count, 32'h0);
  endtask

  initial begin
    logic [31:0] word;
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    expPc      = 32'h0;
    expRet     = 32'h0;
    expInstr   = 32'h0;
    #2;
    checkResetValues("reset");

    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("idleReq", imem_req, 1'b0);
    @(negedge clk);

    applyStimulus(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8C08_0004, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h1000_FFFF, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("jumpTarget", pc, 32'h0000_0100);

    for (int n = 0; n < 150; n++) begin
      word = $urandom;
      applyStimulus(word, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Reset dropped mid-FETCH while memory acks in the same cycle.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(negedge clk);
    checkResetValues("heldReset");
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    expPc    = 32'h0;
    expRet   = 32'h0;
    expInstr = 32'h0;
    checkOutput("restartIdle", imem_req, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0020, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h1000_0003, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
